// File: rtl/pad_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pad_input_conditioner
// Description : Conditions asynchronous pad inputs for the SoC clock domain.
//               UART RX goes through a plain synchroniser. GPIO inputs are
//               synchronised, glitch-filtered on a prescaled sample tick, and
//               latched into sticky rise/fall flags that drive a level IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_input_conditioner #(
    parameter int N_GPIO      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_DIV    = 16,
    parameter int FILT_LEN    = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_uart_rx_pad,
    output logic              o_uart_rx,
    input  logic [N_GPIO-1:0] i_gpio_pad,
    input  logic [N_GPIO-1:0] i_gpio_oen,
    output logic [N_GPIO-1:0] o_gpio,
    output logic [N_GPIO-1:0] o_rise,
    output logic [N_GPIO-1:0] o_fall,
    input  logic [N_GPIO-1:0] i_clr_rise,
    input  logic [N_GPIO-1:0] i_clr_fall,
    output logic              o_irq
);

    // Prescaler needs at least one bit even when every cycle is a tick.
    localparam int c_DIV_W = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
    localparam int c_CNT_W = $clog2(FILT_LEN) + 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(FILT_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_uart_sync;
    logic [N_GPIO-1:0]      r_gpio_sync [SYNC_STAGES];
    logic [c_DIV_W-1:0]     r_presc;
    logic [c_CNT_W-1:0]     r_cnt [N_GPIO];
    logic [N_GPIO-1:0]      r_gpio;
    logic [N_GPIO-1:0]      r_rise;
    logic [N_GPIO-1:0]      r_fall;

    logic                   w_tick;
    logic [N_GPIO-1:0]      w_sync;
    logic [N_GPIO-1:0]      w_differ;
    logic [N_GPIO-1:0]      w_accept;
    logic [N_GPIO-1:0]      w_set_rise;
    logic [N_GPIO-1:0]      w_set_fall;

    // UART RX synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uart_sync <= '1;
        end else begin
            r_uart_sync <= {r_uart_sync[SYNC_STAGES-2:0], i_uart_rx_pad};
        end
    end

    // GPIO synchroniser chains, one vector per stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_gpio_sync[i] <= '0;
            end
        end else begin
            r_gpio_sync[0] <= i_gpio_pad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_gpio_sync[i] <= r_gpio_sync[i-1];
            end
        end
    end

    // Filter sample prescaler: free-running 0..FILT_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A new level is accepted only on the tick that completes a full run of
    // disagreeing samples; the flag set terms fall out of the same condition.
    always_comb begin
        w_tick     = (r_presc == c_DIV_LAST);
        w_sync     = r_gpio_sync[SYNC_STAGES-1];
        w_differ   = w_sync ^ r_gpio;
        w_accept   = '0;
        for (int k = 0; k < N_GPIO; k++) begin
            w_accept[k] = w_tick & w_differ[k] & (r_cnt[k] == c_CNT_LAST);
        end
        w_set_rise = w_accept &  w_sync & i_gpio_oen;
        w_set_fall = w_accept & ~w_sync & i_gpio_oen;
    end

    // Per-pin stability counters and filtered level; an agreeing tick or an
    // acceptance restarts the count, so it never passes FILT_LEN-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_GPIO; k++) begin
                r_cnt[k] <= '0;
            end
            r_gpio <= '0;
        end else begin
            if (w_tick) begin
                for (int k = 0; k < N_GPIO; k++) begin
                    if (!w_differ[k] || w_accept[k]) begin
                        r_cnt[k] <= '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end
            end
            r_gpio <= r_gpio ^ w_accept;
        end
    end

    // Sticky edge flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_set_rise | (r_rise & ~i_clr_rise);
            r_fall <= w_set_fall | (r_fall & ~i_clr_fall);
        end
    end

    assign o_uart_rx = r_uart_sync[SYNC_STAGES-1];
    assign o_gpio    = r_gpio;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_irq     = |(r_rise | r_fall);

endmodule
`default_nettype wire
